// File: rtl/med_log_uart_reader_if.sv
// Scheduler-side log write port, dump request and status/serial outputs
// of the medication log reader, bundled for connection as one port.
interface med_log_uart_reader_if #(
  parameter int DEPTH = 16
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             log_valid;
  logic [7:0]       log_data;
  logic             dump_req;
  logic             tx;
  logic             busy;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             dump_done;

  modport master (
    output log_valid, log_data, dump_req,
    input  tx, busy, count, overflow, dump_done
  );

  modport slave (
    input  log_valid, log_data, dump_req,
    output tx, busy, count, overflow, dump_done
  );
endinterface

// File: rtl/med_log_uart_reader.sv
// Medication event log: circular byte buffer that, on request, dumps a
// snapshot as 8N1 frames (0xA5 header, entry count, then the entries).
module med_log_uart_reader #(
  parameter int DEPTH        = 16,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  med_log_uart_reader_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int CLK_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [1:0] {IDLE, HDR, LEN, DATA} state_t;

  state_t           state, state_next;
  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count_q, n_snap, remaining;
  logic [CLK_W-1:0] clk_cnt;
  logic [3:0]       bit_idx;
  logic [7:0]       shreg;
  logic             tx_q, busy_q, overflow_q, done_q;

  logic             accept, start_frame, pop, finish;
  logic             full, push_ok, drop, bit_end, frame_end;
  logic [7:0]       frame_byte;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign bit_end   = (clk_cnt == CLK_W'(CLKS_PER_BIT - 1));
  assign frame_end = bit_end && (bit_idx == 4'd9);
  // A pop in the same cycle frees the slot, so a full buffer still accepts.
  assign push_ok   = bus.log_valid && (!full || pop);
  assign drop      = bus.log_valid && full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    start_frame = 1'b0;
    pop         = 1'b0;
    finish      = 1'b0;
    frame_byte  = 8'h00;
    unique case (state)
      IDLE: if (bus.dump_req) begin
        accept      = 1'b1;
        start_frame = 1'b1;
        frame_byte  = 8'hA5;
        state_next  = HDR;
      end
      HDR: if (frame_end) begin
        start_frame = 1'b1;
        frame_byte  = 8'(n_snap);
        state_next  = LEN;
      end
      LEN, DATA: if (frame_end) begin
        if (remaining != '0) begin
          start_frame = 1'b1;
          pop         = 1'b1;
          frame_byte  = mem[rd_ptr];
          state_next  = DATA;
        end else begin
          finish      = 1'b1;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: the log storage has no reset; its contents are only meaningful below count.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= bus.log_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_ok, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (drop)        overflow_q <= 1'b1;
      else if (accept) overflow_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      n_snap    <= '0;
      remaining <= '0;
    end else begin
      done_q <= finish;
      if (accept) begin
        busy_q    <= 1'b1;
        n_snap    <= count_q;
        remaining <= count_q;
      end else if (pop) begin
        remaining <= remaining - 1'b1;
      end
      if (finish) busy_q <= 1'b0;
    end
  end

  // Serializer: bit_idx 0 is the start bit, 1..8 data LSB first, 9 the stop bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_q    <= 1'b1;
      clk_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else if (start_frame) begin
      tx_q    <= 1'b0;
      clk_cnt <= '0;
      bit_idx <= '0;
      shreg   <= frame_byte;
    end else if (finish) begin
      tx_q    <= 1'b1;
      clk_cnt <= '0;
      bit_idx <= '0;
    end else if (state != IDLE) begin
      if (bit_end) begin
        clk_cnt <= '0;
        bit_idx <= bit_idx + 1'b1;
        if (bit_idx == 4'd8) begin
          tx_q <= 1'b1;
        end else begin
          tx_q  <= shreg[0];
          shreg <= {1'b0, shreg[7:1]};
        end
      end else begin
        clk_cnt <= clk_cnt + 1'b1;
      end
    end
  end

  assign bus.tx        = tx_q;
  assign bus.busy      = busy_q;
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;
  assign bus.dump_done = done_q;
endmodule

// File: tb/tb_med_log_uart_reader.sv
// Directed bench for med_log_uart_reader: table-driven writes plus cycle-exact
// decoding of each dump frame on tx.
module tb_med_log_uart_reader;
  localparam int DEPTH = 16;
  localparam int CPB   = 4;

  typedef struct {
    logic [7:0] data;
    logic [4:0] exp_count;
    logic       exp_ovf;
  } wr_vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  wr_vec_t    vecs [54];
  logic [7:0] exp_bytes [18];

  med_log_uart_reader_if #(.DEPTH(DEPTH)) bus ();

  med_log_uart_reader #(.DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One write per cycle; occupancy and overflow checked after each edge.
  task automatic apply_writes(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      bus.log_valid = 1'b1;
      bus.log_data  = vecs[i].data;
      @(negedge clk);
      bus.log_valid = 1'b0;
      check($sformatf("wr%0d_count", i), 32'(bus.count), 32'(vecs[i].exp_count));
      check($sformatf("wr%0d_ovf", i), 32'(bus.overflow), 32'(vecs[i].exp_ovf));
    end
  endtask

  task automatic set_hdr(input logic [7:0] n);
    exp_bytes[0] = 8'hA5;
    exp_bytes[1] = n;
  endtask

  // Starts at a negedge; decodes nframes frames sampling every cycle.
  task automatic do_dump(input int nframes, input int inj_cyc, input bit inj_write,
                         input logic [7:0] inj_data);
    logic [9:0] got;
    logic       stable, busy_ok;
    int         c;
    stable  = 1'b1;
    busy_ok = 1'b1;
    got     = '0;
    bus.dump_req = 1'b1;
    @(posedge clk);
    for (int f = 0; f < nframes; f++) begin
      for (int b = 0; b < 10; b++) begin
        for (int k = 0; k < CPB; k++) begin
          c = (f * 10 + b) * CPB + k;
          @(negedge clk);
          bus.dump_req  = 1'b0;
          bus.log_valid = 1'b0;
          if (k == 0) got[b] = bus.tx;
          else if (bus.tx !== got[b]) stable = 1'b0;
          if (bus.busy !== 1'b1 || bus.dump_done !== 1'b0) busy_ok = 1'b0;
          if (c == 0) check("ovf_cleared", 32'(bus.overflow), 32'd0);
          if (c == inj_cyc) begin
            if (inj_write) begin
              bus.log_valid = 1'b1;
              bus.log_data  = inj_data;
            end else begin
              bus.dump_req = 1'b1;
            end
          end
        end
      end
      check($sformatf("frame%0d", f), 32'(got), 32'({1'b1, exp_bytes[f], 1'b0}));
    end
    check("bit_hold", 32'(stable), 32'd1);
    check("busy_window", 32'(busy_ok), 32'd1);
    @(negedge clk);
    check("done_pulse", 32'(bus.dump_done), 32'd1);
    check("busy_end", 32'(bus.busy), 32'd0);
    check("tx_idle_end", 32'(bus.tx), 32'd1);
    @(negedge clk);
    check("done_once", 32'(bus.dump_done), 32'd0);
  endtask

  initial begin
    bus.log_valid = 1'b0;
    bus.log_data  = 8'h00;
    bus.dump_req  = 1'b0;

    vecs[0] = '{8'h12, 5'd1, 1'b0};
    vecs[1] = '{8'h34, 5'd2, 1'b0};
    vecs[2] = '{8'h56, 5'd3, 1'b0};
    for (int i = 0; i < 17; i++)
      vecs[3 + i] = '{8'(i), (i < 16) ? 5'(i + 1) : 5'd16, (i == 16)};
    vecs[20] = '{8'hAA, 5'd1, 1'b0};
    vecs[21] = '{8'hBB, 5'd2, 1'b0};
    for (int i = 0; i < 16; i++) begin
      vecs[22 + i] = '{8'(8'h20 + i), 5'(i + 1), 1'b0};
      vecs[38 + i] = '{8'(8'h30 + i), 5'(i + 1), 1'b0};
    end

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(bus.tx), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_tx", 32'(bus.tx), 32'd1);
    check("post_rst_busy", 32'(bus.busy), 32'd0);
    check("post_rst_count", 32'(bus.count), 32'd0);
    check("post_rst_ovf", 32'(bus.overflow), 32'd0);
    check("post_rst_done", 32'(bus.dump_done), 32'd0);

    // Basic dump with an ignored dump_req in the middle
    apply_writes(0, 2);
    set_hdr(8'h03);
    exp_bytes[2] = 8'h12; exp_bytes[3] = 8'h34; exp_bytes[4] = 8'h56;
    do_dump(5, 90, 1'b0, 8'h00);
    check("basic_count", 32'(bus.count), 32'd0);
    repeat (10) begin
      @(negedge clk);
      if (bus.busy !== 1'b0 || bus.tx !== 1'b1) break;
    end
    check("no_requeue_busy", 32'(bus.busy), 32'd0);
    check("no_requeue_tx", 32'(bus.tx), 32'd1);

    // Empty dump
    set_hdr(8'h00);
    do_dump(2, -1, 1'b0, 8'h00);
    check("empty_count", 32'(bus.count), 32'd0);

    // Overflow then dump
    apply_writes(3, 19);
    set_hdr(8'h10);
    for (int i = 0; i < 16; i++) exp_bytes[2 + i] = 8'(i);
    do_dump(18, -1, 1'b0, 8'h00);
    check("ovf_after_dump", 32'(bus.overflow), 32'd0);
    check("ovf_dump_count", 32'(bus.count), 32'd0);

    // Write during the LEN frame stays for the next dump
    apply_writes(20, 21);
    set_hdr(8'h02);
    exp_bytes[2] = 8'hAA; exp_bytes[3] = 8'hBB;
    do_dump(4, 10 * CPB + 10, 1'b1, 8'h77);
    check("concurrent_count", 32'(bus.count), 32'd1);
    set_hdr(8'h01);
    exp_bytes[2] = 8'h77;
    do_dump(3, -1, 1'b0, 8'h00);
    check("second_count", 32'(bus.count), 32'd0);

    // Full buffer twice across the pointer wrap
    apply_writes(22, 37);
    set_hdr(8'h10);
    for (int i = 0; i < 16; i++) exp_bytes[2 + i] = 8'(8'h20 + i);
    do_dump(18, -1, 1'b0, 8'h00);
    apply_writes(38, 53);
    for (int i = 0; i < 16; i++) exp_bytes[2 + i] = 8'(8'h30 + i);
    do_dump(18, -1, 1'b0, 8'h00);
    check("wrap_count", 32'(bus.count), 32'd0);
    check("wrap_ovf", 32'(bus.overflow), 32'd0);

    // Asynchronous reset in the middle of header BIT3 (0xA5 bit 3 = 0)
    apply_writes(0, 1);
    bus.dump_req = 1'b1;
    @(posedge clk);
    for (int c = 0; c <= 17; c++) begin
      @(negedge clk);
      bus.dump_req = 1'b0;
    end
    check("bit3_tx", 32'(bus.tx), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_tx", 32'(bus.tx), 32'd1);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_count", 32'(bus.count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("after_midrst_tx", 32'(bus.tx), 32'd1);
    check("after_midrst_busy", 32'(bus.busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/med_log_uart_reader.md
Name: med_log_uart_reader

Overview:
Read-out end of the medication event log. It captures log entries from the scheduler, one byte per event holding the counter value at that event, into a 16-deep circular buffer. On request it drains a snapshot of the buffer onto a UART-style serial line so the log can be read off-chip. The block sits between the scheduler's log-write strobe and a dedicated output pin.

Parameters:
DEPTH, 16, number of log entries held (power of two)
CLKS_PER_BIT, 4, clock cycles per serial bit (minimum 2)

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  reset, asynchronous, active-low
log_valid  input  1  one-cycle write strobe from scheduler
log_data  input  8  log entry (counter value at the event)
dump_req  input  1  request to transmit the log; sampled only in IDLE
tx  output  1  serial line; idle high, 8N1, LSB first
busy  output  1  high from dump acceptance until dump_done
count  output  5  current occupancy, 0..DEPTH
overflow  output  1  sticky; a write was dropped because the buffer was full
dump_done  output  1  one-cycle pulse when a dump finishes

Behaviour:
- Reset (asynchronous, immediate, including mid-frame): tx=1, busy=0, count=0, overflow=0, dump_done=0.
- Reset also clears both pointers, the state machine and the bit counters. Buffer contents are don't-care.
- Write side: log_valid with count<DEPTH stores log_data at wr_ptr, then wr_ptr++ (wraps DEPTH-1 to 0).
- Full case: log_valid with count==DEPTH and no pop that cycle drops the data and sets overflow.
- Full case with a pop in the same cycle: the write is accepted and count stays at DEPTH.
- Simultaneous push and pop leaves count unchanged.
- Writes are accepted in every state, including during a dump.
- State machine: IDLE, HDR, LEN, DATA.
- A shared serializer runs START (tx=0), BIT0..BIT7 (tx=data[i]) and STOP (tx=1).
- Each serial bit is held exactly CLKS_PER_BIT cycles. tx is registered.
- IDLE: when dump_req=1 at an edge:
  - snapshot N=count
  - clear overflow; if a drop happens in that same cycle, set wins
  - busy<=1 and tx<=0, so the header start bit appears the cycle after the request
  - go to HDR
- HDR: send byte 0xA5, then go to LEN.
- LEN: send byte {3'b0,N}.
  - N>0: go to DATA.
  - N==0: finish.
- DATA: each frame pops one entry. The byte is read at rd_ptr, then rd_ptr++ and count--, at the edge that starts that frame's start bit. The block sends exactly N entries, oldest first.
- Frames run back-to-back with no idle gap, so a dump lasts (2+N)*10*CLKS_PER_BIT cycles.
- Finish: at the edge ending the last stop bit:
  - dump_done=1 for exactly one cycle
  - busy=0
  - return to IDLE with tx=1
- dump_req while busy is ignored; it is not queued.
- Entries written during a dump are not in the snapshot. They stay in the buffer for the next dump.
- count is always the live occupancy and is never clamped.

Test Plan:
- Reset check: hold rst_n=0, then release -> tx=1, busy=0, count=0, overflow=0. Assert rst_n=0 mid-frame at BIT3 -> tx=1 and busy=0 at once, count=0.
- Basic dump (CLKS_PER_BIT=4): write 0x12, 0x34, 0x56, then pulse dump_req -> tx carries frames A5, 03, 12, 34, 56, LSB first, 200 cycles total. dump_done pulses once, count=0 afterwards.
- Empty dump: dump_req with count=0 -> frames A5, 00 only. dump_done comes after 80 cycles; busy stays high for that whole window.
- Overflow: write 17 entries 0x00..0x10 -> count=16, overflow=1, 0x10 dropped. Then dump -> A5, 10, 00..0F, overflow=0 from the cycle after acceptance.
- Concurrent write: write 0xAA, 0xBB, dump, and write 0x77 during the LEN frame -> transmitted A5, 02, AA, BB, final count=1. A second dump sends A5, 01, 77.
- Busy ignore and full wrap: pulse dump_req during a dump -> no effect, no extra frames. Fill to 16, dump, refill past the pointer wrap, dump again -> order preserved, no drops.
